// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory request arbiter: default channel ids,
// arbitration-mode encoding, FSM state type and age-counter sizing.
// Optional MEM_ARB_AGE_EN build uses the AGE_* constants.
package mem_arbiter_pkg;

  // Default transaction ids owned by the data cache, instruction cache and frame buffer
  localparam logic [1:0] ID_DC = 2'd1;
  localparam logic [1:0] ID_IC = 2'd2;
  localparam logic [1:0] ID_FB = 2'd3;

  // Arbitration mode encoding for the RR parameter
  localparam int ARB_FIXED = 0;  // highest requesting index wins
  localparam int ARB_RR    = 1;  // round-robin after last accepted channel

  // Arbiter FSM states
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Starvation counter sizing
  localparam int         AGE_W   = 8;
  localparam logic [7:0] AGE_MAX = 8'hFF;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Winner selection: request vector plus round-robin pointer -> one-hot grant.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides when the pointer advances.
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int NCH   = 3,
  parameter int RR    = ARB_FIXED,
  parameter int PTR_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]   req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NCH-1:0]   grant
);

  logic [PTR_W-1:0] cand;

  // Scan candidates so the last hit written is the policy winner
  always_comb begin
    grant = '0;
    cand  = '0;
    if (RR == ARB_RR) begin
      // Walk from the farthest offset down to ptr+1 so the nearest requester after ptr wins
      for (int off = NCH; off >= 1; off--) begin
        cand = PTR_W'((int'(ptr) + off) % NCH);
        if (req[cand]) begin
          grant       = '0;
          grant[cand] = 1'b1;
        end
      end
    end else begin
      // Ascending scan leaves the highest requesting index granted
      for (int i = 0; i < NCH; i++) begin
        if (req[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel to one memory-controller request arbiter; fields forwarded combinationally.
// Latency: zero added cycles; a stalled winner is locked until the controller accepts it.
// Backpressure: mem_waitrequest reflected to the granted channel, all others stalled.
// Optional feature: define MEM_ARB_AGE_EN for per-channel starvation counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int                  NCH    = 3,
  parameter int                  ADDR_W = 30,
  parameter int                  DATA_W = 32,
  parameter int                  ID_W   = 2,
  parameter int                  RR     = ARB_FIXED,
  parameter logic [NCH*ID_W-1:0] CH_ID  = {ID_FB, ID_IC, ID_DC}
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NCH-1:0]             ch_read,
  input  logic [NCH-1:0]             ch_write,
  input  logic [NCH*ADDR_W-1:0]      ch_address,
  input  logic [NCH*DATA_W-1:0]      ch_writedata,
  input  logic [NCH*(DATA_W/8)-1:0]  ch_writedatamask,
  input  logic [NCH*ID_W-1:0]        ch_id,
  output logic [NCH-1:0]             ch_waitrequest,
  output logic [NCH-1:0]             ch_readdatavalid,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [DATA_W-1:0]          mem_writedata,
  output logic [DATA_W/8-1:0]        mem_writedatamask,
  output logic [ID_W-1:0]            mem_id,
  input  logic                       mem_waitrequest,
  input  logic [ID_W-1:0]            mem_readdataid
);

  localparam int MASK_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(NCH);

  arb_state_t       state;
  logic [NCH-1:0]   req;
  logic [NCH-1:0]   lock_gnt;
  logic [NCH-1:0]   pick_gnt;
  logic [NCH-1:0]   idle_gnt;
  logic [NCH-1:0]   grant;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic             accept;

  assign req = ch_read | ch_write;

  arb_pick #(
    .NCH   (NCH),
    .RR    (RR),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_gnt)
  );

`ifdef MEM_ARB_AGE_EN
  logic [AGE_W-1:0] age [NCH];
  logic [NCH-1:0]   aged_req;
  logic [NCH-1:0]   aged_gnt;

  // Starved requesters override the normal policy, lowest index first
  always_comb begin
    aged_req = '0;
    aged_gnt = '0;
    for (int i = 0; i < NCH; i++) begin
      aged_req[i] = req[i] && (age[i] == AGE_MAX);
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (aged_req[i]) begin
        aged_gnt    = '0;
        aged_gnt[i] = 1'b1;
      end
    end
    idle_gnt = (|aged_req) ? aged_gnt : pick_gnt;
  end

  // Saturating wait counters: count unaccepted requesting cycles, clear on acceptance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (accept && grant[i]) begin
          age[i] <= '0;
        end else if (req[i] && (age[i] != AGE_MAX)) begin
          age[i] <= age[i] + 1'b1;
        end
      end
    end
  end
`else
  assign idle_gnt = pick_gnt;
`endif

  // Current grant: fresh pick in IDLE, the held channel in LOCKED, nothing during reset
  always_comb begin
    grant = '0;
    if (!reset) begin
      if (state == ST_IDLE) grant = idle_gnt;
      else                  grant = lock_gnt & req;
    end
  end

  // Forward the granted channel's request fields and encode its index
  always_comb begin
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_address       = '0;
    mem_writedata     = '0;
    mem_writedatamask = '0;
    mem_id            = '0;
    gnt_idx           = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        mem_read          = ch_read[i];
        mem_write         = ch_write[i];
        mem_address       = ch_address[i*ADDR_W +: ADDR_W];
        mem_writedata     = ch_writedata[i*DATA_W +: DATA_W];
        mem_writedatamask = ch_writedatamask[i*MASK_W +: MASK_W];
        mem_id            = ch_id[i*ID_W +: ID_W];
        gnt_idx           = PTR_W'(i);
      end
    end
  end

  assign accept         = (mem_read | mem_write) & ~mem_waitrequest;
  assign ch_waitrequest = ~grant | {NCH{mem_waitrequest}};

  // Route returning read ids to their owner; id 0 is reserved and matches nobody
  always_comb begin
    ch_readdatavalid = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_readdatavalid[i] = (mem_readdataid != '0) &&
                            (mem_readdataid == CH_ID[i*ID_W +: ID_W]);
    end
  end

  // Lock FSM and round-robin pointer; pointer starts at NCH-1 so channel 0 wins first
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      lock_gnt <= '0;
      ptr      <= PTR_W'(NCH - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if ((|grant) && !accept) begin
            state    <= ST_LOCKED;
            lock_gnt <= grant;
          end
        end
        ST_LOCKED: begin
          // Leave on acceptance, or if the locked master withdrew its request
          if (accept || !(|(lock_gnt & req))) begin
            state    <= ST_IDLE;
            lock_gnt <= '0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          lock_gnt <= '0;
        end
      endcase
      if (accept) ptr <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: fixed-priority and round-robin instances share stimulus.
// Expected acceptances (cycle and fields) are queued by the stimulus and popped by a monitor.
// Simple master model holds each request until its channel sees waitrequest low.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int NCH    = 3;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int ID_W   = 2;
  localparam int MASK_W = DATA_W / 8;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
    logic [ID_W-1:0]   id;
    logic              wr;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                      reset;
  logic [NCH-1:0]            ch_read, ch_write;
  logic [NCH*ADDR_W-1:0]     ch_address;
  logic [NCH*DATA_W-1:0]     ch_writedata;
  logic [NCH*MASK_W-1:0]     ch_writedatamask;
  logic [NCH*ID_W-1:0]       ch_id;
  logic                      mem_waitrequest;
  logic [ID_W-1:0]           mem_readdataid;

  logic [NCH-1:0]    fp_wait, rr_wait, fp_rdv, rr_rdv;
  logic              fp_rd, rr_rd, fp_wr, rr_wr;
  logic [ADDR_W-1:0] fp_addr, rr_addr;
  logic [DATA_W-1:0] fp_data, rr_data;
  logic [MASK_W-1:0] fp_mask, rr_mask;
  logic [ID_W-1:0]   fp_id, rr_id;

  mem_arbiter #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .RR(ARB_FIXED)) dut_fp (
    .clock(clock), .reset(reset), .ch_read(ch_read), .ch_write(ch_write),
    .ch_address(ch_address), .ch_writedata(ch_writedata), .ch_writedatamask(ch_writedatamask),
    .ch_id(ch_id), .ch_waitrequest(fp_wait), .ch_readdatavalid(fp_rdv),
    .mem_read(fp_rd), .mem_write(fp_wr), .mem_address(fp_addr), .mem_writedata(fp_data),
    .mem_writedatamask(fp_mask), .mem_id(fp_id), .mem_waitrequest(mem_waitrequest),
    .mem_readdataid(mem_readdataid));

  mem_arbiter #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .RR(ARB_RR)) dut_rr (
    .clock(clock), .reset(reset), .ch_read(ch_read), .ch_write(ch_write),
    .ch_address(ch_address), .ch_writedata(ch_writedata), .ch_writedatamask(ch_writedatamask),
    .ch_id(ch_id), .ch_waitrequest(rr_wait), .ch_readdatavalid(rr_rdv),
    .mem_read(rr_rd), .mem_write(rr_wr), .mem_address(rr_addr), .mem_writedata(rr_data),
    .mem_writedatamask(rr_mask), .mem_id(rr_id), .mem_waitrequest(mem_waitrequest),
    .mem_readdataid(mem_readdataid));

  // The active instance is the one the masters follow and the monitor checks
  logic act_rr = 1'b0;
  logic              a_rd, a_wr;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic [MASK_W-1:0] a_mask;
  logic [ID_W-1:0]   a_id;
  logic [NCH-1:0]    a_wait;
  assign a_rd   = act_rr ? rr_rd   : fp_rd;
  assign a_wr   = act_rr ? rr_wr   : fp_wr;
  assign a_addr = act_rr ? rr_addr : fp_addr;
  assign a_data = act_rr ? rr_data : fp_data;
  assign a_mask = act_rr ? rr_mask : fp_mask;
  assign a_id   = act_rr ? rr_id   : fp_id;
  assign a_wait = act_rr ? rr_wait : fp_wait;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   rem[NCH];
  int   seq[NCH];
  logic [NCH-1:0] acc_s;
  int   c0;

  function automatic logic [ADDR_W-1:0] addr_of(int i, int s);
    return ADDR_W'(32'h1000 * (i + 1) + s);
  endfunction
  function automatic logic [DATA_W-1:0] data_of(int i, int s);
    return DATA_W'(32'hA500_0000 | (i << 16) | s);
  endfunction
  function automatic logic [MASK_W-1:0] mask_of(int i, int s);
    return MASK_W'(i + s + 1);
  endfunction
  function automatic logic wr_of(int i, int s);
    return ((i + s) % 2) == 1;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expect channel i's request k positions ahead of its current one, accepted in cycle c
  task automatic push(int i, int k, int c);
    exp_t e;
    e.cyc  = c;
    e.addr = addr_of(i, seq[i] + k);
    e.data = data_of(i, seq[i] + k);
    e.mask = mask_of(i, seq[i] + k);
    e.id   = ID_W'(i + 1);
    e.wr   = wr_of(i, seq[i] + k);
    exp_q.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      ch_read[i]  = (rem[i] > 0) && !wr_of(i, seq[i]);
      ch_write[i] = (rem[i] > 0) &&  wr_of(i, seq[i]);
      ch_address[i*ADDR_W +: ADDR_W]       = addr_of(i, seq[i]);
      ch_writedata[i*DATA_W +: DATA_W]     = data_of(i, seq[i]);
      ch_writedatamask[i*MASK_W +: MASK_W] = mask_of(i, seq[i]);
      ch_id[i*ID_W +: ID_W]                = ID_W'(i + 1);
    end
  endtask

  // One clock: note which channels were accepted, then advance those masters
  task automatic tick();
    @(negedge clock);
    acc_s = (ch_read | ch_write) & ~a_wait & {NCH{!reset}};
    @(posedge clock);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (acc_s[i]) begin
        rem[i]--;
        seq[i]++;
      end
    end
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NCH; i++) rem[i] = 0;
    mem_waitrequest = 1'b0;
    mem_readdataid  = '0;
    drive();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic end_test(string name);
    chk(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && (a_rd || a_wr) && !mem_waitrequest) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: accept at cycle %0d addr %0h, none required", cyc, a_addr);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.cyc || a_addr !== e.addr || a_data !== e.data || a_mask !== e.mask ||
              a_id !== e.id || a_wr !== e.wr || a_rd !== !e.wr) begin
            n_fail++;
            $display("FAIL sb_accept: got cyc %0d addr %0h data %0h mask %0h id %0h rd %0b wr %0b, required cyc %0d addr %0h data %0h mask %0h id %0h wr %0b",
                     cyc, a_addr, a_data, a_mask, a_id, a_rd, a_wr,
                     e.cyc, e.addr, e.data, e.mask, e.id, e.wr);
          end
        end
      end
    end
  endtask

  logic [ID_W-1:0] rid_tab [4] = '{2'd2, 2'd0, 2'd3, 2'd1};
  logic [NCH-1:0]  rdv_tab [4] = '{3'b010, 3'b000, 3'b100, 3'b001};

  initial begin
    reset = 1'b1;
    ch_read = '0; ch_write = '0; ch_address = '0; ch_writedata = '0;
    ch_writedatamask = '0; ch_id = '0; mem_waitrequest = 1'b0; mem_readdataid = '0;
    for (int i = 0; i < NCH; i++) begin rem[i] = 0; seq[i] = 0; end
    fork monitor(); join_none

    // Reset state: nothing granted, everyone stalled
    @(posedge clock); #1;
    chk("rst_fp_strobes", {fp_rd, fp_wr}, 2'b00);
    chk("rst_fp_wait", fp_wait, 3'b111);
    chk("rst_rr_wait", rr_wait, 3'b111);

    // Fixed priority: ch0 and ch2 together -> ch2 then ch0 back to back
    act_rr = 1'b0;
    do_reset();
    c0 = cyc;
    push(2, 0, c0); push(0, 0, c0 + 1);
    rem[0] = 1; rem[2] = 1; drive();
    repeat (3) tick();
    end_test("t1_drained");

    // Round-robin: all three continuously -> 0,1,2,0,1,2
    act_rr = 1'b1;
    do_reset();
    c0 = cyc;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NCH; i++) push(i, r, c0 + 3 * r + i);
    for (int i = 0; i < NCH; i++) rem[i] = 2;
    drive();
    repeat (7) tick();
    end_test("t2_drained");

    // Stall: ch1 locked through 4 waitrequest cycles while ch2 joins; ch2 follows
    act_rr = 1'b0;
    do_reset();
    mem_waitrequest = 1'b1;
    rem[1] = 1;
    c0 = cyc;
    push(1, 0, c0 + 4); push(2, 0, c0 + 5);
    drive();
    for (int k = 1; k <= 5; k++) begin
      if (k == 2) begin rem[2] = 1; drive(); end
      if (k == 5) mem_waitrequest = 1'b0;
      #1;
      chk("t3_addr_hold", a_addr, addr_of(1, seq[1]));
      if (k == 2) chk("t3_wait_stalled", a_wait, 3'b111);
      if (k == 5) chk("t3_wait_release", a_wait, 3'b101);
      tick();
    end
    tick();
    end_test("t3_drained");

    // Read return routing by id, one cycle at a time
    for (int k = 0; k < 4; k++) begin
      mem_readdataid = rid_tab[k];
      #1;
      chk("t4_rdv_fp", fp_rdv, rdv_tab[k]);
      chk("t4_rdv_rr", rr_rdv, rdv_tab[k]);
      tick();
    end
    mem_readdataid = '0;

    // Reset while locked: strobes drop at once, first grant afterwards is channel 0
    act_rr = 1'b1;
    do_reset();
    rem[0] = 1;
    c0 = cyc;
    push(0, 0, c0);
    drive();
    tick();
    rem[1] = 1; rem[2] = 1; mem_waitrequest = 1'b1;
    drive();
    tick();
    #1;
    chk("t5_locked_strobe", {a_rd | a_wr}, 1'b1);
    chk("t5_locked_addr", a_addr, addr_of(1, seq[1]));
    reset = 1'b1;
    #1;
    chk("t5_rst_strobes", {a_rd, a_wr}, 2'b00);
    chk("t5_rst_wait", a_wait, 3'b111);
    tick();
    reset = 1'b0;
    mem_waitrequest = 1'b0;
    rem[0] = 1;
    c0 = cyc;
    push(0, 0, c0); push(1, 0, c0 + 1); push(2, 0, c0 + 2);
    drive();
    repeat (4) tick();
    end_test("t5_drained");

`ifdef MEM_ARB_AGE_EN
    // Starvation: ch0 loses to ch2 for 255 cycles, then wins once
    act_rr = 1'b0;
    do_reset();
    rem[2] = 256; rem[0] = 1;
    c0 = cyc;
    for (int k = 0; k < 255; k++) push(2, k, c0 + k);
    push(0, 0, c0 + 255);
    push(2, 255, c0 + 256);
    drive();
    repeat (258) tick();
    end_test("t6_drained");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
